sr_event_gen: RTL and testbench
===============================

SR_EVENT_GEN -- requirements
Module: sr_event_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized cycles required to accept an input level change (range 1..255).
REQ-002 Parameter MIN_GAP, default 4, minimum number of idle cycles between any two output pulses (range 1..255).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 set_in  input  1  asynchronous raw "set" event line (button/external pin).
REQ-006 rst_in  input  1  asynchronous raw "reset" event line.
REQ-007 clr_ovf  input  1  synchronous clear of the sticky overflow flag.
REQ-008 s_pulse  output  1  one-cycle set strobe to the downstream SR flip-flop s input.
REQ-009 r_pulse  output  1  one-cycle reset strobe to the downstream SR flip-flop r input.
REQ-010 ovf  output  1  sticky flag: an event was dropped.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Per channel, a debounce counter SHALL increment while synchronized value differs from debounced value, and SHALL clear whenever they are equal.
REQ-013 Debounced value SHALL take the synchronized value on the edge at which the counter has seen DEBOUNCE_CYCLES consecutive differing cycles; the counter then clears.
REQ-014 A rising edge of a debounced value SHALL raise that channel's pending flag; falling edges SHALL be ignored.
REQ-015 A rising debounced edge on a channel whose pending flag is already set SHALL be dropped and SHALL set ovf.
REQ-016 FSM states: IDLE, PULSE, GAP.
REQ-017 IDLE: if any pending flag is set, go to PULSE, asserting exactly one output for that PULSE cycle and clearing the served pending flag.
REQ-018 Service priority: r pending SHALL win over s pending; the losing s event stays pending (never merged, never both outputs together).
REQ-019 s_pulse and r_pulse SHALL never be high in the same cycle and each SHALL be high for exactly one cycle per served event.
REQ-020 PULSE -> GAP unconditionally; GAP SHALL last exactly MIN_GAP cycles, then -> IDLE.
REQ-021 Events arriving during PULSE or GAP SHALL be held pending, served in IDLE per REQ-017/018.
REQ-022 A pending flag set and served in the same cycle is impossible by construction: a flag set in cycle N is served no earlier than the IDLE decision at cycle N+1.
REQ-023 Latency, uncontended, from first edge sampling a stable high set_in to s_pulse high: 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-024 clr_ovf SHALL clear ovf next edge; a simultaneous new overflow SHALL win (ovf stays 1).
REQ-025 Gap counter width SHALL be 8 bits; no wrap beyond MIN_GAP.

Reset
REQ-026 While rst_n low at a clock edge: synchronizers, debounced values 0, counters 0, pending flags 0, FSM IDLE, s_pulse 0, r_pulse 0, ovf 0.
REQ-027 Reset mid-PULSE or mid-GAP SHALL discard all pending events; no pulse is issued for pre-reset events.
REQ-028 An input held high through reset release SHALL produce one pulse after full debounce (debounced starts at 0).

Structure
REQ-029 FSM state encoding and the 8-bit counter width constant SHALL live in the shared utils package.
REQ-030 One sub-module, sync_debounce (synchronizer + debounce counter + rising-edge detect), SHALL be instantiated twice, once per channel.

Verification (DEBOUNCE_CYCLES=4, MIN_GAP=3)
REQ-031 set_in high from cycle 10, held -> s_pulse high only at cycle 17, r_pulse never.
REQ-032 set_in 1-cycle glitches every 3 cycles for 30 cycles -> no s_pulse, no r_pulse, ovf 0.
REQ-033 set_in and rst_in rise same cycle 10 -> r_pulse at 17, s_pulse at 21 (PULSE + 3 GAP), never overlapping.
REQ-034 rst_in rises, r_pulse served; during its GAP rst_in toggles to a second debounced rise with a third rise before service -> second pulse issued once, ovf=1; clr_ovf pulse -> ovf=0 next cycle.
REQ-035 rst_n low for one cycle during GAP with s pending -> no s_pulse afterward, all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/sr_event_gen_pkg.sv
// Shared definitions for the SR event generator: FSM encoding and counter width.
package sr_event_gen_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } fsm_state_t;

  // Terminal value of a counter that must span n cycles (n >= 1).
  function automatic logic [CNT_W-1:0] last_count(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/sr_event_gen_sync_debounce.sv
// One input channel: 2-flop synchronizer, debounce counter and rising-edge strobe.
module sync_debounce
  import sr_event_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = last_count(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic             debounced;
  logic [CNT_W-1:0] cnt;

  // rise is a one-cycle strobe registered on the same edge the debounced level goes high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      debounced <= 1'b0;
      cnt       <= '0;
      rise      <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == debounced) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        debounced <= sync2;
        cnt       <= '0;
        rise      <= sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sr_event_gen.sv
// Turns debounced set/reset events into exclusive, rate-limited one-cycle strobes
// for a downstream SR flip-flop, with a sticky flag for dropped events.
module sr_event_gen
  import sr_event_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MIN_GAP         = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_in,
  input  logic rst_in,
  input  logic clr_ovf,
  output logic s_pulse,
  output logic r_pulse,
  output logic ovf
);

  localparam logic [CNT_W-1:0] GAP_LAST = last_count(MIN_GAP);

  logic             s_rise;
  logic             r_rise;
  fsm_state_t       state;
  fsm_state_t       state_next;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] gap_cnt_next;
  logic             pend_s;
  logic             pend_r;
  logic             pend_s_next;
  logic             pend_r_next;
  logic             can_serve;
  logic             serve_s;
  logic             serve_r;
  logic             drop;
  logic             ovf_next;

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_ch (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_in (set_in),
    .rise   (s_rise)
  );

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_ch (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_in (rst_in),
    .rise   (r_rise)
  );

  // The last GAP cycle makes the IDLE decision itself so a queued event follows
  // exactly MIN_GAP idle cycles after the previous pulse.
  always_comb begin
    state_next   = state;
    gap_cnt_next = gap_cnt;
    can_serve    = 1'b0;
    serve_s      = 1'b0;
    serve_r      = 1'b0;

    unique case (state)
      IDLE: can_serve = 1'b1;
      PULSE: begin
        state_next   = GAP;
        gap_cnt_next = '0;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = IDLE;
          can_serve  = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (can_serve) begin
      if (pend_r) begin
        serve_r    = 1'b1;
        state_next = PULSE;
      end else if (pend_s) begin
        serve_s    = 1'b1;
        state_next = PULSE;
      end
    end
  end

  // A rise lands in a flag being served this cycle without loss; otherwise it is dropped.
  always_comb begin
    pend_s_next = (pend_s & ~serve_s) | s_rise;
    pend_r_next = (pend_r & ~serve_r) | r_rise;
    drop        = (s_rise & pend_s & ~serve_s) | (r_rise & pend_r & ~serve_r);
    ovf_next    = ovf;
    if (drop) begin
      ovf_next = 1'b1;
    end else if (clr_ovf) begin
      ovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
      pend_s  <= 1'b0;
      pend_r  <= 1'b0;
      s_pulse <= 1'b0;
      r_pulse <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_cnt_next;
      pend_s  <= pend_s_next;
      pend_r  <= pend_r_next;
      s_pulse <= serve_s;
      r_pulse <= serve_r;
      ovf     <= ovf_next;
    end
  end

endmodule

// File: tb/tb_sr_event_gen.sv
// Directed bench for sr_event_gen: main instance (DEBOUNCE 4, GAP 3) plus a fast-debounce,
// long-gap instance that can actually queue a second event and overflow.
module tb_sr_event_gen;
  import sr_event_gen_pkg::*;

  logic clk = 1'b0;
  logic rst_n, set_in, rst_in, clr_ovf;
  logic s_pulse, r_pulse, ovf;
  logic rst_n2, set_in2, rst_in2, clr_ovf2;
  logic s_pulse2, r_pulse2, ovf2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_event_gen #(.DEBOUNCE_CYCLES(4), .MIN_GAP(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_in  (set_in),
    .rst_in  (rst_in),
    .clr_ovf (clr_ovf),
    .s_pulse (s_pulse),
    .r_pulse (r_pulse),
    .ovf     (ovf)
  );

  sr_event_gen #(.DEBOUNCE_CYCLES(1), .MIN_GAP(12)) dut_ovf (
    .clk     (clk),
    .rst_n   (rst_n2),
    .set_in  (set_in2),
    .rst_in  (rst_in2),
    .clr_ovf (clr_ovf2),
    .s_pulse (s_pulse2),
    .r_pulse (r_pulse2),
    .ovf     (ovf2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst_n high so the next edge is cycle 1 of a scenario.
  task automatic reset_main();
    rst_n   = 1'b0;
    set_in  = 1'b0;
    rst_in  = 1'b0;
    clr_ovf = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n2 = 1'b0; set_in2 = 1'b0; rst_in2 = 1'b0; clr_ovf2 = 1'b0;
    rst_n = 1'b0; set_in = 1'b1; rst_in = 1'b1; clr_ovf = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ({s_pulse, r_pulse, ovf} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle %0d: got s/r/ovf=%b required 000", c, {s_pulse, r_pulse, ovf});
      end
      checks++;
      if (dut.state !== IDLE) begin
        errors++;
        $display("[TB] FAIL reset_state cycle %0d: got %0d required IDLE", c, dut.state);
      end
    end
    reset_main();
    rst_n2 = 1'b1;
  endtask

  task automatic test_set_latency();
    reset_main();
    for (int c = 1; c <= 30; c++) begin
      set_in = (c >= 10);
      tick();
      checks++;
      if (s_pulse !== (c == 17) || r_pulse !== 1'b0) begin
        errors++;
        $display("[TB] FAIL set_latency cycle %0d: got s=%b r=%b required s=%b r=0", c, s_pulse, r_pulse, (c == 17));
      end
    end
  endtask

  task automatic test_glitch();
    reset_main();
    for (int c = 1; c <= 45; c++) begin
      set_in = (c >= 10 && c < 40 && ((c - 10) % 3 == 0));
      tick();
      checks++;
      if ({s_pulse, r_pulse, ovf} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL glitch cycle %0d: got s/r/ovf=%b required 000", c, {s_pulse, r_pulse, ovf});
      end
    end
  endtask

  task automatic test_priority();
    reset_main();
    for (int c = 1; c <= 32; c++) begin
      set_in = (c >= 10);
      rst_in = (c >= 10);
      tick();
      checks++;
      if (r_pulse !== (c == 17) || s_pulse !== (c == 21)) begin
        errors++;
        $display("[TB] FAIL priority cycle %0d: got r=%b s=%b required r=%b s=%b",
                 c, r_pulse, s_pulse, (c == 17), (c == 21));
      end
    end
  endtask

  task automatic test_reset_in_gap();
    reset_main();
    for (int c = 1; c <= 40; c++) begin
      set_in = (c >= 10 && c < 19);
      rst_in = (c >= 10 && c < 19);
      rst_n  = (c != 19);
      tick();
      checks++;
      if (r_pulse !== (c == 17) || s_pulse !== 1'b0 || ovf !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_in_gap cycle %0d: got r=%b s=%b ovf=%b required r=%b s=0 ovf=0",
                 c, r_pulse, s_pulse, ovf, (c == 17));
      end
      if (c == 19) begin
        checks++;
        if (dut.state !== IDLE) begin
          errors++;
          $display("[TB] FAIL reset_in_gap_state: got %0d required IDLE", dut.state);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_hold_through_reset();
    rst_n  = 1'b0;
    set_in = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++;
      if (s_pulse !== (c == 8) || r_pulse !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_through_reset cycle %0d: got s=%b r=%b required s=%b r=0", c, s_pulse, r_pulse, (c == 8));
      end
    end
    set_in = 1'b0;
  endtask

  function automatic logic burst(input int o);
    return (o >= 0 && o <= 5) || (o >= 8 && o <= 9) || (o >= 12);
  endfunction

  // Two bursts: the second drops an event on the same edge clr_ovf is asserted.
  task automatic test_overflow();
    rst_n2 = 1'b0; set_in2 = 1'b0; rst_in2 = 1'b0; clr_ovf2 = 1'b0;
    tick();
    tick();
    rst_n2 = 1'b1;
    for (int c = 1; c <= 75; c++) begin
      rst_in2  = (c < 40) ? burst(c - 10) : burst(c - 50);
      clr_ovf2 = (c == 35 || c == 65);
      tick();
      checks++;
      if (r_pulse2 !== (c == 14 || c == 27 || c == 54 || c == 67) || s_pulse2 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL overflow_pulse cycle %0d: got r=%b s=%b required r=%b s=0",
                 c, r_pulse2, s_pulse2, (c == 14 || c == 27 || c == 54 || c == 67));
      end
      checks++;
      if (ovf2 !== ((c >= 25 && c < 35) || c >= 65)) begin
        errors++;
        $display("[TB] FAIL overflow_flag cycle %0d: got ovf=%b required %b",
                 c, ovf2, ((c >= 25 && c < 35) || c >= 65));
      end
    end
    rst_in2  = 1'b0;
    clr_ovf2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_set_latency();
    test_glitch();
    test_priority();
    test_reset_in_gap();
    test_hold_through_reset();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
